// File: rtl/status_table_drain.sv
// Captures indexed table writes and, on a sticky status request, drains every
// valid entry lowest-index-first over a valid/ready port, then pulses status_ack.
module status_table_drain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              status_in,
    output logic              status_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic [7:0]        sent_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] table_q [DEPTH];
    logic [DATA_W-1:0] table_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  mask_q, mask_d;
    logic [DEPTH-1:0]  wr_onehot;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              status_ack_q, status_ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        sent_cnt_q, sent_cnt_d;
    logic [IDX_W-1:0]  sel;
    logic              sel_found;

    always_comb begin
        wr_onehot = '0;
        if (wr_en) wr_onehot[wr_idx] = 1'b1;
    end

    // Priority pick of the lowest pending entry in the round snapshot.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && mask_q[i]) begin
                sel       = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        table_d      = table_q;
        vld_d        = vld_q | wr_onehot;
        mask_d       = mask_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_idx_d    = out_idx_q;
        status_ack_d = 1'b0;
        sent_cnt_d   = sent_cnt_q;

        if (wr_en) table_d[wr_idx] = wr_data;

        case (state_q)
            IDLE: begin
                if (status_in) begin
                    mask_d  = vld_q | wr_onehot;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (mask_q == '0) begin
                    status_ack_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = table_q[sel];
                    out_idx_d   = sel;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_d       = 1'b0;
                    mask_d[out_idx_q] = 1'b0;
                    // A same-cycle rewrite of the sent entry keeps it valid for a later round.
                    if (!(wr_en && (wr_idx == out_idx_q))) vld_d[out_idx_q] = 1'b0;
                    sent_cnt_d = sent_cnt_q + 8'd1;
                    state_d    = SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            table_q      <= '{default: '0};
            vld_q        <= '0;
            mask_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            status_ack_q <= 1'b0;
            busy_q       <= 1'b0;
            sent_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            table_q      <= table_d;
            vld_q        <= vld_d;
            mask_q       <= mask_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            status_ack_q <= status_ack_d;
            busy_q       <= busy_d;
            sent_cnt_q   <= sent_cnt_d;
        end
    end

    assign status_ack = status_ack_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign busy       = busy_q;
    assign sent_cnt   = sent_cnt_q;

endmodule
